adc_capture: RTL
================

Name: adc_capture

Overview:
- Parametrised, triggered ADC capture engine; successor to the plain ADC-to-SPI sample path.
- Samples adc_data on rising edges of the divided ADDA clock, with optional decimation.
- Keeps a circular buffer with a programmable pre-trigger window and supports level/edge/external triggering.
- Once the capture completes, exposes the record in time order for SPI-side readout.

Parameters:
- DATA_W, 8, ADC sample width.
- ADDR_W, 4, buffer address width; DEPTH = 2**ADDR_W samples.
- DEC_W, 8, decimation counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; asynchronous, active-high
- adc_clk  in  1  divided ADDA sample clock; treated as data and synchronised internally
- adc_data  in  DATA_W  ADC sample bus
- arm  in  1  single-cycle pulse; starts a capture
- abort  in  1  single-cycle pulse; cancels a capture
- trig_mode  in  2  00 immediate, 01 rising level cross, 10 falling level cross, 11 external
- trig_level  in  DATA_W  unsigned threshold
- ext_trig  in  1  external trigger level
- pre_len  in  ADDR_W  number of samples kept before the trigger sample
- decim  in  DEC_W  store one sample per decim+1 adc_clk rising edges
- rd_req  in  1  read strobe, one sample per pulse
- rd_data  out  DATA_W  readout sample
- rd_valid  out  1  rd_data valid; one-cycle pulse
- busy  out  1  capture in progress
- triggered  out  1  trigger seen in current capture
- done  out  1  record complete and readable

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0.
  - Pointers, counters, synchronisers and the decimation counter are 0.
  - Memory contents are don't-care.
- Edge detect:
  - adc_clk passes through a 2-FF synchroniser (s1, s2).
  - edge = s1 & ~s2.
  - adc_data and ext_trig are registered on the edge cycle.
  - Sample instant = edge cycle + 1.
- Decimation:
  - dcnt counts edges only while busy.
  - A sample is stored when dcnt==0, then dcnt reloads to decim.
  - Otherwise dcnt decrements.
  - arm clears dcnt, so the first edge after arm is always stored.
- Storage: each stored sample is written to mem[wr_ptr]; wr_ptr then increments mod DEPTH (wrap-around allowed).
- Trigger, evaluated only in ARMED, on the stored sample cur against the previous stored sample prev:
  - immediate: always fires.
  - rising: prev < trig_level && cur >= trig_level.
  - falling: prev > trig_level && cur <= trig_level.
  - external: registered ext_trig==1.
  - Edge modes never fire on the first stored sample after arm (no valid prev).
- FSM:
  - IDLE: on arm, set wr_ptr=0, cnt=0, busy=1, triggered=0, done=0. Go to ARMED if pre_len==0, else PRE.
  - PRE: store samples with no trigger evaluation. When the stored count reaches pre_len, go to ARMED.
  - ARMED: store samples, overwriting old ones. On a trigger sample at address A:
    - Set trig_addr=A and triggered=1.
    - Set post = DEPTH-1-pre_len.
    - Go to DONE if post==0, else POST.
  - POST: store samples, decrementing post per stored sample. At 0, go to DONE.
  - DONE:
    - busy=0, done=1.
    - rd_ptr = trig_addr - pre_len, mod DEPTH.
- Readout, only in DONE:
  - rd_req reads mem[rd_ptr].
  - rd_data and rd_valid appear on the next cycle (synchronous RAM, 1-cycle latency); rd_ptr increments mod DEPTH.
  - After DEPTH reads, readout wraps to the first sample again.
  - rd_req outside DONE is ignored and rd_valid stays 0.
- Record contents: exactly DEPTH samples, oldest first, with the trigger sample at index pre_len.
- Control priority:
  - abort in any state returns to IDLE and clears busy, triggered and done.
  - abort beats arm in the same cycle.
  - arm in PRE, ARMED or POST is ignored.
  - arm in DONE restarts the capture, clearing done.
- Configuration (trig_mode, trig_level, pre_len, decim) must be stable from arm until done; they are sampled live.

Test Plan:
- DEPTH=16, decim=0, trig_mode=00, pre_len=0, ramp starting 0x10, step 1 per edge; arm → triggered on the first sample; done after 16 stored samples; 16 rd_req return 0x10..0x1F with one-cycle latency, and the 17th read returns 0x10.
- trig_mode=01, trig_level=0x80, pre_len=4, ramp from 0x70 step 1 → trigger on 0x80; readout is 0x7C..0x8B; triggered=1, done=1.
- decim=2, immediate mode, ramp step 1 from 0x00 → stored samples are 0x00,0x03,…,0x2D (stride 3); done after 46 edges.
- trig_mode=10, trig_level=0x40, constant input 0x90 → remains ARMED with busy=1, done=0; abort → busy=0 next cycle; rd_req yields no rd_valid.
- trig_mode=11, pre_len=2, ext_trig pulsed around sample 0x25 of a ramp → readout starts at 0x23.
- reset asserted mid-POST → all outputs 0 immediately; arm after release gives a clean capture matching scenario 1.

Source files
------------

// File: rtl/adc_capture.sv
// adc_capture: triggered ADC capture into a circular buffer with pre-trigger window,
// decimation and time-ordered readout once the record is complete.
module adc_capture #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEC_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adc_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic              abort,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              ext_trig,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [DEC_W-1:0]  decim,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              triggered,
    output logic              done
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

    state_t            r_state;
    logic              r_s1, r_s2, r_st, r_ext, r_has_prev;
    logic              r_busy, r_trig, r_done, r_rd_valid;
    logic [DATA_W-1:0] r_smp, r_prev, r_rd_data;
    logic [DEC_W-1:0]  r_dcnt;
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, r_cnt, r_post, r_trig_addr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_edge, w_capt, w_wr, w_start, w_rd;
    logic              w_rise, w_fall, w_fire;
    logic [ADDR_W-1:0] w_post_init;

    assign w_edge  = r_s1 & ~r_s2;
    assign w_capt  = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_wr    = r_st & w_capt;
    assign w_start = arm & ~abort & ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_rd    = rd_req & ~abort & ~w_start & (r_state == S_DONE);
    // DEPTH-1-pre_len is simply the bitwise complement when DEPTH is a power of two
    assign w_post_init = ~pre_len;

    assign w_rise = r_has_prev && (r_prev < trig_level) && (r_smp >= trig_level);
    assign w_fall = r_has_prev && (r_prev > trig_level) && (r_smp <= trig_level);
    assign w_fire = (trig_mode == 2'b00) ? 1'b1 :
                    (trig_mode == 2'b01) ? w_rise :
                    (trig_mode == 2'b10) ? w_fall : r_ext;

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign busy      = r_busy;
    assign triggered = r_trig;
    assign done      = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_st        <= 1'b0;
            r_ext       <= 1'b0;
            r_has_prev  <= 1'b0;
            r_busy      <= 1'b0;
            r_trig      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_smp       <= '0;
            r_prev      <= '0;
            r_dcnt      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_post      <= '0;
            r_trig_addr <= '0;
        end else begin
            r_s1       <= adc_clk;
            r_s2       <= r_s1;
            r_rd_valid <= w_rd;
            r_st       <= 1'b0;
            if (w_edge) begin
                r_smp <= adc_data;
                r_ext <= ext_trig;
                r_st  <= r_busy && (r_dcnt == '0);
                if (r_busy)
                    r_dcnt <= (r_dcnt == '0) ? decim : r_dcnt - 1'b1;
            end
            if (w_wr) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_prev     <= r_smp;
                r_has_prev <= 1'b1;
            end
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_trig  <= 1'b0;
                r_done  <= 1'b0;
            end else if (w_start) begin
                r_state    <= (pre_len == '0) ? S_ARMED : S_PRE;
                r_wr_ptr   <= '0;
                r_cnt      <= '0;
                r_dcnt     <= '0;
                r_has_prev <= 1'b0;
                r_busy     <= 1'b1;
                r_trig     <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    S_PRE: if (r_st) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt + 1'b1 == pre_len)
                            r_state <= S_ARMED;
                    end
                    S_ARMED: if (r_st && w_fire) begin
                        r_trig_addr <= r_wr_ptr;
                        r_trig      <= 1'b1;
                        r_post      <= w_post_init;
                        if (w_post_init == '0) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_rd_ptr <= r_wr_ptr - pre_len;
                        end else begin
                            r_state <= S_POST;
                        end
                    end
                    S_POST: if (r_st) begin
                        r_post <= r_post - 1'b1;
                        if (r_post == ADDR_W'(1)) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_rd_ptr <= r_trig_addr - pre_len;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= r_smp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rd_data <= '0;
        else if (w_rd)
            r_rd_data <= r_mem[r_rd_ptr];
    end
endmodule
